// File: rtl/shade_dither.sv
// Colour-output stage: per-scene palette plus 4x4 ordered dither into 2-bit RGB, syncs delayed to match.
// Optional SHADE_DITHER_TEMPORAL_EN rotates the Bayer column each frame via a 4-bit frame counter.
module shade_dither #(
    parameter int V_MID = 240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hit,
    input  logic [5:0]  luma,
    input  logic [10:0] h_count,
    input  logic [9:0]  v_count,
    input  logic        display_en,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [1:0]  scene_select,
    output logic [1:0]  r,
    output logic [1:0]  g,
    output logic [1:0]  b,
    output logic        hsync_out,
    output logic        vsync_out
);

    localparam logic [9:0] VMID = 10'(V_MID);

    // Channel weight codes: 0 -> off, 1 -> 1/4, 2 -> 1/2, 3 -> full.
    localparam logic [1:0] W_OFF = 2'd0;
    localparam logic [1:0] W_QTR = 2'd1;
    localparam logic [1:0] W_HLF = 2'd2;
    localparam logic [1:0] W_ONE = 2'd3;

    function automatic logic [3:0] bayer_t(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] t;
        case ({row, col})
            4'h0: t = 4'd0;   4'h1: t = 4'd8;   4'h2: t = 4'd2;   4'h3: t = 4'd10;
            4'h4: t = 4'd12;  4'h5: t = 4'd4;   4'h6: t = 4'd14;  4'h7: t = 4'd6;
            4'h8: t = 4'd3;   4'h9: t = 4'd11;  4'hA: t = 4'd1;   4'hB: t = 4'd9;
            4'hC: t = 4'd15;  4'hD: t = 4'd7;   4'hE: t = 4'd13;  default: t = 4'd5;
        endcase
        return t;
    endfunction

    function automatic logic [5:0] scale(input logic [5:0] l, input logic [1:0] w);
        logic [5:0] s;
        case (w)
            W_OFF:   s = 6'd0;
            W_QTR:   s = l >> 2;
            W_HLF:   s = l >> 1;
            default: s = l;
        endcase
        return s;
    endfunction

    // Round up by one level when the fraction beats the threshold, saturating at 3.
    function automatic logic [1:0] quant(input logic [5:0] s, input logic [3:0] t);
        logic [1:0] q;
        q = s[5:4];
        if ((s[3:0] > t) && (q != 2'd3)) q = q + 2'd1;
        return q;
    endfunction

    // Stage 1
    logic       hit_q, de_q, hs1_q, vs1_q, above_q;
    logic [5:0] luma_q;
    logic [3:0] thr_q, thr_d;
    // Stage 2 / outputs
    logic [1:0] r_q, g_q, b_q, r_d, g_d, b_d;
    logic       hs2_q, vs2_q;
    // Frame state
    logic [1:0] scene_q, scene_d;
    logic       vs_fall;
    logic [1:0] col;
    logic [1:0] wr, wg, wb;
`ifdef SHADE_DITHER_TEMPORAL_EN
    logic [3:0] frame_q, frame_d;
`endif

    logic unused_hcnt;
    assign unused_hcnt = ^h_count[10:2];

    always_comb begin
        vs_fall = vs2_q & ~vs1_q;
        scene_d = vs_fall ? scene_select : scene_q;
`ifdef SHADE_DITHER_TEMPORAL_EN
        // Next-frame count so the pixel sampled alongside the palette switch also gets the new offset.
        frame_d = vs_fall ? frame_q + 4'd1 : frame_q;
        col     = h_count[1:0] ^ frame_d[1:0];
`else
        col     = h_count[1:0];
`endif
        thr_d = bayer_t(v_count[1:0], col);

        wr = W_ONE;
        wg = W_ONE;
        wb = W_ONE;
        case (scene_q)
            2'd1:    begin wr = W_ONE; wg = W_HLF; wb = W_OFF; end
            2'd2:    begin wr = W_OFF; wg = W_ONE; wb = W_ONE; end
            2'd3:    begin wr = W_QTR; wg = W_ONE; wb = W_QTR; end
            default: begin wr = W_ONE; wg = W_ONE; wb = W_ONE; end
        endcase

        r_d = 2'd0;
        g_d = 2'd0;
        b_d = 2'd0;
        if (!de_q) begin
            r_d = 2'd0;
        end else if (!hit_q) begin
            b_d = above_q ? 2'd1 : 2'd0;
        end else begin
            r_d = quant(scale(luma_q, wr), thr_q);
            g_d = quant(scale(luma_q, wg), thr_q);
            b_d = quant(scale(luma_q, wb), thr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q   <= 1'b0;
            luma_q  <= 6'd0;
            de_q    <= 1'b0;
            hs1_q   <= 1'b1;
            vs1_q   <= 1'b1;
            above_q <= 1'b0;
            thr_q   <= 4'd0;
            hs2_q   <= 1'b1;
            vs2_q   <= 1'b1;
            r_q     <= 2'd0;
            g_q     <= 2'd0;
            b_q     <= 2'd0;
            scene_q <= 2'd0;
`ifdef SHADE_DITHER_TEMPORAL_EN
            frame_q <= 4'd0;
`endif
        end else begin
            hit_q   <= hit;
            luma_q  <= luma;
            de_q    <= display_en;
            hs1_q   <= hsync_in;
            vs1_q   <= vsync_in;
            above_q <= (v_count < VMID);
            thr_q   <= thr_d;
            hs2_q   <= hs1_q;
            vs2_q   <= vs1_q;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            scene_q <= scene_d;
`ifdef SHADE_DITHER_TEMPORAL_EN
            frame_q <= frame_d;
`endif
        end
    end

    assign r         = r_q;
    assign g         = g_q;
    assign b         = b_q;
    assign hsync_out = hs2_q;
    assign vsync_out = vs2_q;

endmodule

// File: tb/tb_shade_dither.sv
// Bench for shade_dither: directed scenarios plus randomized traffic against a behavioural model.
module tb_shade_dither;

    localparam int V_MID = 240;
    localparam int BAYER [16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};
    // Channel weights in quarters, per scene: R, G, B.
    localparam int WGT [12] = '{4, 4, 4,  4, 2, 0,  0, 4, 4,  1, 4, 1};

    typedef struct packed {
        logic [1:0] r, g, b;
        logic       hs, vs;
    } pix_t;
    localparam pix_t IDLE = '{r: 2'd0, g: 2'd0, b: 2'd0, hs: 1'b1, vs: 1'b1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hit = 1'b0;
    logic [5:0]  luma = 6'd0;
    logic [10:0] h_count = 11'd0;
    logic [9:0]  v_count = 10'd0;
    logic        display_en = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [1:0]  scene_select = 2'd0;
    logic [1:0]  r, g, b;
    logic        hsync_out, vsync_out;

    int errs = 0;
    int checks = 0;

    shade_dither #(.V_MID(V_MID)) dut (
        .clk(clk), .rst(rst), .hit(hit), .luma(luma), .h_count(h_count), .v_count(v_count),
        .display_en(display_en), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .scene_select(scene_select), .r(r), .g(g), .b(b),
        .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    always #5 clk = ~clk;

    // Reference model: the colour for a pixel follows directly from the palette/dither arithmetic.
    function automatic pix_t model_pix(input int ht, input int lm, input int hc, input int vc,
                                       input int de, input int hs, input int vs,
                                       input int sc, input int fr);
        pix_t p;
        int t, s, lv;
        int lvl [3];
        p = IDLE;
        p.hs = hs[0];
        p.vs = vs[0];
        t = BAYER[(vc % 4) * 4 + ((hc % 4) ^ (fr % 4))];
        for (int c = 0; c < 3; c++) begin
            s  = lm * WGT[sc * 3 + c] / 4;
            lv = s / 16 + (((s % 16) > t) ? 1 : 0);
            lvl[c] = (lv > 3) ? 3 : lv;
        end
        if (de == 0) begin
            p.b = 2'd0;
        end else if (ht == 0) begin
            p.b = (vc < V_MID) ? 2'd1 : 2'd0;
        end else begin
            p.r = 2'(lvl[0]);
            p.g = 2'(lvl[1]);
            p.b = 2'(lvl[2]);
        end
        return p;
    endfunction

    pix_t st1_m, out_m;
    logic vsp1, vsp2, fall_m;
    int   scene_m, frame_m, scene_now, frame_now;
    assign fall_m    = vsp2 && !vsp1;
    assign scene_now = fall_m ? int'(scene_select) : scene_m;
`ifdef SHADE_DITHER_TEMPORAL_EN
    assign frame_now = fall_m ? (frame_m + 1) % 16 : frame_m;
`else
    assign frame_now = 0;
`endif

    always @(posedge clk) begin
        if (rst) begin
            st1_m   <= IDLE;
            out_m   <= IDLE;
            vsp1    <= 1'b1;
            vsp2    <= 1'b1;
            scene_m <= 0;
            frame_m <= 0;
        end else begin
            scene_m <= scene_now;
            frame_m <= frame_now;
            st1_m   <= model_pix(int'(hit), int'(luma), int'(h_count), int'(v_count),
                                 int'(display_en), int'(hsync_in), int'(vsync_in),
                                 scene_now, frame_now);
            out_m   <= st1_m;
            vsp2    <= vsp1;
            vsp1    <= vsync_in;
        end
    end

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        hit = 1'b1;
        luma = 6'($urandom);
        display_en = 1'b1;
        hsync_in = 1'b0;
        vsync_in = 1'b1;
        h_count = 11'($urandom);
        v_count = 10'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({r, g, b, hsync_out, vsync_out} !== 8'b00000011) begin
                errs++;
                $display("FAIL reset_hold[%0d]: got r=%0d g=%0d b=%0d hs=%b vs=%b want 0/0/0 hs=1 vs=1",
                         i, r, g, b, hsync_out, vsync_out);
            end
        end
        rst = 1'b0;
        checks++;
        if ({r, g, b, hsync_out, vsync_out} !== 8'b00000011) begin
            errs++;
            $display("FAIL reset_release0: got r=%0d g=%0d b=%0d hs=%b want 0/0/0 hs=1", r, g, b, hsync_out);
        end
        @(negedge clk);
        checks++;
        if ({r, g, b, hsync_out, vsync_out} !== 8'b00000011) begin
            errs++;
            $display("FAIL reset_release1: got r=%0d g=%0d b=%0d hs=%b want 0/0/0 hs=1", r, g, b, hsync_out);
        end
        hsync_in = 1'b1;
        @(negedge clk);
        checks++;
        if (hsync_out !== 1'b0) begin
            errs++;
            $display("FAIL reset_first_sample: got hsync_out=%b want 0", hsync_out);
        end
    endtask

    task automatic test_dither();
        scene_select = 2'd0;
        hit = 1'b1;
        display_en = 1'b1;
        luma = 6'd40;
        v_count = 10'd0;
        h_count = 11'd0;
        settle();
        checks++;
        if ({r, g, b} !== 6'b111111) begin
            errs++;
            $display("FAIL dither_h0: got r=%0d g=%0d b=%0d want 3/3/3", r, g, b);
        end
        h_count = 11'd1;
        settle();
        checks++;
        if ({r, g, b} !== 6'b101010) begin
            errs++;
            $display("FAIL dither_h1: got r=%0d g=%0d b=%0d want 2/2/2", r, g, b);
        end
        luma = 6'd63;
        settle();
        checks++;
        if ({r, g, b} !== 6'b111111) begin
            errs++;
            $display("FAIL dither_sat: got r=%0d g=%0d b=%0d want 3/3/3", r, g, b);
        end
    endtask

    task automatic test_background();
        hit = 1'b0;
        display_en = 1'b1;
        h_count = 11'd5;
        v_count = 10'd10;
        settle();
        checks++;
        if ({r, g, b} !== 6'b000001) begin
            errs++;
            $display("FAIL bg_sky: got r=%0d g=%0d b=%0d want 0/0/1", r, g, b);
        end
        v_count = 10'(V_MID - 1);
        settle();
        checks++;
        if ({r, g, b} !== 6'b000001) begin
            errs++;
            $display("FAIL bg_edge_sky: got r=%0d g=%0d b=%0d want 0/0/1", r, g, b);
        end
        v_count = 10'(V_MID);
        settle();
        checks++;
        if ({r, g, b} !== 6'b000000) begin
            errs++;
            $display("FAIL bg_edge_ground: got r=%0d g=%0d b=%0d want 0/0/0", r, g, b);
        end
        v_count = 10'd300;
        settle();
        checks++;
        if ({r, g, b} !== 6'b000000) begin
            errs++;
            $display("FAIL bg_ground: got r=%0d g=%0d b=%0d want 0/0/0", r, g, b);
        end
        display_en = 1'b0;
        hit = 1'b1;
        luma = 6'd63;
        v_count = 10'd10;
        settle();
        checks++;
        if ({r, g, b} !== 6'b000000) begin
            errs++;
            $display("FAIL blank: got r=%0d g=%0d b=%0d want 0/0/0", r, g, b);
        end
        display_en = 1'b1;
    endtask

    task automatic test_scene_latch();
        hit = 1'b1;
        display_en = 1'b1;
        luma = 6'd63;
        h_count = 11'd0;
        v_count = 10'd0;
        scene_select = 2'd1;
        vsync_in = 1'b0;
        repeat (4) @(negedge clk);
        vsync_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({r, g, b} !== 6'b111000) begin
            errs++;
            $display("FAIL scene1: got r=%0d g=%0d b=%0d want 3/2/0", r, g, b);
        end
        scene_select = 2'd2;
        repeat (5) @(negedge clk);
        checks++;
        if ({r, g, b} !== 6'b111000) begin
            errs++;
            $display("FAIL scene_midframe: got r=%0d g=%0d b=%0d want 3/2/0", r, g, b);
        end
        vsync_in = 1'b0;
        @(negedge clk);
        vsync_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({r, g, b} !== 6'b001111) begin
            errs++;
            $display("FAIL scene2: got r=%0d g=%0d b=%0d want 0/3/3", r, g, b);
        end
    endtask

    task automatic test_sync();
        hsync_in = 1'b0;
        @(negedge clk);
        hsync_in = 1'b1;
        checks++;
        if (hsync_out !== 1'b1) begin
            errs++;
            $display("FAIL hsync_t1: got %b want 1", hsync_out);
        end
        @(negedge clk);
        checks++;
        if ({hsync_out, vsync_out} !== 2'b01) begin
            errs++;
            $display("FAIL hsync_t2: got hs=%b vs=%b want hs=0 vs=1", hsync_out, vsync_out);
        end
        @(negedge clk);
        checks++;
        if (hsync_out !== 1'b1) begin
            errs++;
            $display("FAIL hsync_t3: got %b want 1", hsync_out);
        end
        vsync_in = 1'b0;
        @(negedge clk);
        vsync_in = 1'b1;
        checks++;
        if (vsync_out !== 1'b1) begin
            errs++;
            $display("FAIL vsync_t1: got %b want 1", vsync_out);
        end
        @(negedge clk);
        checks++;
        if ({hsync_out, vsync_out} !== 2'b10) begin
            errs++;
            $display("FAIL vsync_t2: got hs=%b vs=%b want hs=1 vs=0", hsync_out, vsync_out);
        end
        @(negedge clk);
        checks++;
        if (vsync_out !== 1'b1) begin
            errs++;
            $display("FAIL vsync_t3: got %b want 1", vsync_out);
        end
    endtask

`ifdef SHADE_DITHER_TEMPORAL_EN
    task automatic test_temporal();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        scene_select = 2'd0;
        hit = 1'b1;
        display_en = 1'b1;
        luma = 6'd40;
        h_count = 11'd0;
        v_count = 10'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({r, g, b} !== 6'b111111) begin
            errs++;
            $display("FAIL temporal_f0: got r=%0d g=%0d b=%0d want 3/3/3", r, g, b);
        end
        vsync_in = 1'b0;
        repeat (5) @(negedge clk);
        vsync_in = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({r, g, b} !== 6'b101010) begin
            errs++;
            $display("FAIL temporal_f1: got r=%0d g=%0d b=%0d want 2/2/2", r, g, b);
        end
        for (int i = 0; i < 15; i++) begin
            vsync_in = 1'b0;
            @(negedge clk);
            vsync_in = 1'b1;
            repeat (2) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({r, g, b} !== 6'b111111) begin
            errs++;
            $display("FAIL temporal_wrap: got r=%0d g=%0d b=%0d want 3/3/3", r, g, b);
        end
    endtask
`endif

    task automatic test_random();
        pix_t act;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            act = '{r: r, g: g, b: b, hs: hsync_out, vs: vsync_out};
            checks++;
            if (act !== out_m) begin
                errs++;
                $display("FAIL random[%0d]: got r=%0d g=%0d b=%0d hs=%b vs=%b want r=%0d g=%0d b=%0d hs=%b vs=%b",
                         i, act.r, act.g, act.b, act.hs, act.vs,
                         out_m.r, out_m.g, out_m.b, out_m.hs, out_m.vs);
            end
            rst          = ($urandom_range(0, 199) == 0);
            hit          = 1'($urandom);
            luma         = 6'($urandom);
            h_count      = 11'($urandom_range(0, 799));
            v_count      = 10'($urandom_range(0, 524));
            display_en   = ($urandom_range(0, 7) != 0);
            hsync_in     = ($urandom_range(0, 7) != 0);
            vsync_in     = ($urandom_range(0, 11) != 0);
            scene_select = 2'($urandom);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_dither();
        test_background();
        test_scene_latch();
        test_sync();
`ifdef SHADE_DITHER_TEMPORAL_EN
        test_temporal();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/shade_dither.md
# shade_dither

Colour-output stage directly downstream of the pipelined renderer. Consumes the per-pixel `hit`/`luma` result and the matching VGA timing, then applies a per-scene palette and 4x4 ordered (Bayer) dithering to quantise 6-bit intensity into 2-bit-per-channel RGB. Delays the sync signals by the same amount, so the RGB and sync outputs drive the TinyTapeout VGA pins directly.

## Interface
Parameters:
- `V_MID`, default 240: first row treated as "ground" for the background gradient.

Ports:
- `clk`  in  1  pixel clock; the block's only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `hit`  in  1  renderer hit flag, aligned with `h_count`/`v_count`.
- `luma`  in  6  renderer intensity, aligned with `hit`.
- `h_count`  in  11  horizontal pixel counter for the current pixel.
- `v_count`  in  10  vertical line counter for the current pixel.
- `display_en`  in  1  1 inside the visible 640x480 area.
- `hsync_in`  in  1  horizontal sync, active-low.
- `vsync_in`  in  1  vertical sync, active-low.
- `scene_select`  in  2  palette request; may change at any time.
- `r`, `g`, `b`  out  2 each  quantised colour, registered.
- `hsync_out`  out  1  `hsync_in` delayed by 2 cycles.
- `vsync_out`  out  1  `vsync_in` delayed by 2 cycles.

## Operation
- **Stage 1** (register):
  - Latches `hit`, `luma`, `display_en`, both syncs, `h_count[1:0]`, `v_count[1:0]`, and the flag `v_count < V_MID`.
  - Computes the Bayer threshold `T`. Matrix rows are `0 8 2 10 / 12 4 14 6 / 3 11 1 9 / 15 7 13 5`. Row index is `v_count[1:0]`; column index is `h_count[1:0]` (the column source changes under the macro; see Configuration).
- **Scene latch:**
  - `scene_q` samples `scene_select` on the falling edge of `vsync_in`, detected from the stage-1 copy against its previous value.
  - `scene_q` is stable for the whole frame, so there is never a mid-frame palette change.
- **Palette:** each channel weight is one of {0, 1/4, 1/2, 1}, applied as a right shift of `luma`, or as 0. The scaled value `s` is 6 bits.
  - Scene 0: R=1, G=1, B=1.
  - Scene 1: R=1, G=1/2, B=0.
  - Scene 2: R=0, G=1, B=1.
  - Scene 3: R=1/4, G=1, B=1/4.
- **Quantise:** `q = s[5:4]`. If `s[3:0] > T` and `q != 3`, output `q+1`; otherwise output `q`. The result saturates at 3 and never wraps.
- **Stage 2** (output register), in priority order:
  - If `display_en` is 0: `r=g=b=0`.
  - Else if `hit` is 0: background. `b=1` when the row is above `V_MID`; all other channels 0.
  - Else: the quantised palette colour.
- **Frame counter:**
  - 4-bit `frame_cnt`, incremented on each detected vsync falling edge, wrapping 15→0.
  - Exists only with the macro defined.
- **Reset:**
  - `r=g=b=0`, `hsync_out=1`, `vsync_out=1`, `scene_q=0`, `frame_cnt=0`.
  - All pipeline registers go to their idle values: syncs 1, everything else 0.
  - A reset asserted mid-frame takes effect on the next `clk` edge. No partial pixel state survives it.

## Timing
- Latency is exactly 2 cycles from an input sample to `r`/`g`/`b` and the sync outputs. Colour and sync stay mutually aligned.
- Throughput is one pixel per clock. There are no stalls and no handshake.
- The scene change becomes visible starting with the first pixel whose stage-1 sample follows the vsync falling edge.
- Edge detection uses the stage-1 `vsync` and its delayed copy. Holding `vsync_in` low for many cycles counts as one edge.
- First output cycle after reset release: outputs reflect the inputs sampled 2 cycles earlier. Before that, outputs hold their reset values.

## Configuration
- Macro: `SHADE_DITHER_TEMPORAL_EN`.
- **Defined:** the Bayer column index is `h_count[1:0] ^ frame_cnt[1:0]`. The dither pattern shifts each frame, so flicker averages out banding.
- **Undefined:** the column index is `h_count[1:0]`; `frame_cnt` is not instantiated; the pattern is static.

## Test plan
- **Reset:** assert `rst` for 3 cycles with arbitrary inputs -> `r=g=b=0` and `hsync_out=vsync_out=1` during reset and for 2 cycles after release.
- **Dither, macro off:** scene 0, `hit=1`, `luma=40`, `display_en=1`, `v_count=0`. Then:
  - `h_count=0` -> `r=g=b=3`, 2 cycles later.
  - `h_count=1` -> `r=g=b=2`.
  - `luma=63` -> all channels 3 (saturation).
- **Background/blank:**
  - `hit=0`, `v_count=10` -> `b=1`, `r=g=0`.
  - `v_count=300` -> all 0.
  - `display_en=0` with `hit=1` and `luma=63` -> all 0.
- **Scene latch:** scene 1, `luma=63`, `h_count=0`, `v_count=0` -> `r=3`, `g=2`, `b=0`. Then:
  - Changing `scene_select` to 2 mid-frame leaves the output unchanged.
  - After the next vsync falling edge -> `r=0`, `g=3`, `b=3`.
- **Sync alignment:** drive a 1-cycle `hsync_in` low pulse -> `hsync_out` low exactly 2 cycles later for 1 cycle. `vsync_in` behaves the same.
- **Temporal, macro on:** `luma=40`, `h_count=0`, `v_count=0` -> output 3 in frame 0. Output 2 in frame 1, where the column index becomes 1 and `T=8`. `frame_cnt` wraps after 16 vsync edges.
